// File: rtl/word_tx_arb_if.sv
// Requester and UART-side signals of word_tx_arb; slave = arbiter, master = environment.
interface word_tx_arb_if;
  logic        req0;
  logic        req1;
  logic [31:0] din0;
  logic [31:0] din1;
  logic        gnt0;
  logic        gnt1;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        busy;
  logic        done;
  logic        owner;

  modport slave (
    input  req0, req1, din0, din1, is_transmitting,
    output gnt0, gnt1, transmit, tx_byte, busy, done, owner
  );

  modport master (
    output req0, req1, din0, din1, is_transmitting,
    input  gnt0, gnt1, transmit, tx_byte, busy, done, owner
  );
endinterface

// File: rtl/word_tx_arb.sv
// Round-robin arbiter feeding 32-bit words byte-wise (LSB first) to a UART, idle gap between words.
// Define WORD_TX_ARB_HDR_EN to prefix each word with header byte 8'hA0 | owner.
module word_tx_arb #(
  parameter int IDLE_GAP = 16
) (
  input  logic             clk,
  input  logic             rst,
  word_tx_arb_if.slave     bus
);

  localparam int GW = (IDLE_GAP < 1) ? 1 : $clog2(IDLE_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(IDLE_GAP);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t        r_state;
  logic [31:0]   r_word;
  logic [1:0]    r_byte_cnt;
  logic [GW-1:0] r_gap;
  logic          r_last;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_transmit;
  logic [7:0]    r_tx_byte;
  logic          r_busy;
  logic          r_done;
  logic          r_owner;

  logic          w_win;
  logic [31:0]   w_din;
  logic [1:0]    w_next_cnt;
  logic [7:0]    w_next_byte;
  logic [7:0]    w_first_byte;
  logic          w_hdr;

  // r_last starts at 1 so requester 0 wins the first contested grant.
  assign w_win       = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
  assign w_din       = w_win ? bus.din1 : bus.din0;
  assign w_next_cnt  = r_byte_cnt + 2'd1;
  assign w_next_byte = r_word[{w_next_cnt, 3'b000} +: 8];

`ifdef WORD_TX_ARB_HDR_EN
  logic r_hdr;
  assign w_hdr        = r_hdr;
  assign w_first_byte = 8'hA0 | {7'b0, w_win};
`else
  assign w_hdr        = 1'b0;
  assign w_first_byte = w_din[7:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_gap      <= '0;
      r_last     <= 1'b1;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_transmit <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_owner    <= 1'b0;
`ifdef WORD_TX_ARB_HDR_EN
      r_hdr      <= 1'b0;
`endif
    end else begin
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_transmit <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_word     <= w_din;
            r_gnt0     <= ~w_win;
            r_gnt1     <= w_win;
            r_owner    <= w_win;
            r_last     <= w_win;
            r_busy     <= 1'b1;
            r_byte_cnt <= 2'd0;
            r_tx_byte  <= w_first_byte;
`ifdef WORD_TX_ARB_HDR_EN
            r_hdr      <= 1'b1;
`endif
            r_state    <= START;
          end
        end
        START: begin
          if (!bus.is_transmitting) begin
            r_transmit <= 1'b1;
            r_state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (bus.is_transmitting) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.is_transmitting) begin
            if (w_hdr) begin
`ifdef WORD_TX_ARB_HDR_EN
              r_hdr     <= 1'b0;
`endif
              r_tx_byte <= r_word[7:0];
              r_state   <= START;
            end else if (r_byte_cnt != 2'd3) begin
              r_byte_cnt <= w_next_cnt;
              r_tx_byte  <= w_next_byte;
              r_state    <= START;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_gap   <= GAP_LOAD;
              r_state <= GAP;
            end
          end
        end
        GAP: begin
          if (r_gap == '0) begin
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0     = r_gnt0;
  assign bus.gnt1     = r_gnt1;
  assign bus.transmit = r_transmit;
  assign bus.tx_byte  = r_tx_byte;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.owner    = r_owner;

endmodule

// File: tb/tb_word_tx_arb.sv
// Scoreboard bench for word_tx_arb: UART model, pulse monitor, one task per scenario.
module tb_word_tx_arb;
  localparam int IDLE_GAP = 16;
  localparam int BUSY_CYC = 10;
`ifdef WORD_TX_ARB_HDR_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  word_tx_arb_if bus();

  word_tx_arb #(.IDLE_GAP(IDLE_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // UART model: busy for BUSY_CYC cycles after each transmit strobe, or while uart_hold is set.
  int ucnt = 0;
  bit uart_hold = 1'b0;
  always @(negedge clk) begin
    if (bus.transmit === 1'b1) ucnt = BUSY_CYC;
    else if (ucnt > 0) ucnt--;
    bus.is_transmitting = uart_hold || (ucnt > 0);
  end

  int n_tx = 0, n_g0 = 0, n_g1 = 0, n_done = 0;
  logic [7:0] obs_q[$];
  bit         g_id_q[$];
  int         g_cyc_q[$];
  int         d_cyc_q[$];
  always @(negedge clk) begin
    if (bus.transmit === 1'b1) begin n_tx++; obs_q.push_back(bus.tx_byte); end
    if (bus.gnt0 === 1'b1) begin n_g0++; g_id_q.push_back(1'b0); g_cyc_q.push_back(cyc); end
    if (bus.gnt1 === 1'b1) begin n_g1++; g_id_q.push_back(1'b1); g_cyc_q.push_back(cyc); end
    if (bus.done === 1'b1) begin n_done++; d_cyc_q.push_back(cyc); end
  end

  logic [7:0] exp_q[$];
  int rd = 0;

  task automatic push_word(input logic own, input logic [31:0] w);
`ifdef WORD_TX_ARB_HDR_EN
    exp_q.push_back(8'hA0 | {7'b0, own});
`endif
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.din0 = '0; bus.din1 = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%b want=0", bus.gnt0); end
    checks++; if (bus.gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%b want=0", bus.gnt1); end
    checks++; if (bus.transmit !== 1'b0) begin failures++; $display("FAIL reset_transmit got=%b want=0", bus.transmit); end
    checks++; if (bus.tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%h want=00", bus.tx_byte); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%b want=0", bus.owner); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_single();
    int t;
    int b_tx = n_tx, b_g0 = n_g0, b_g1 = n_g1, b_d = n_done;
    logic [7:0] e;
    bus.din0 = 32'h04030201; bus.req0 = 1'b1;
    push_word(1'b0, 32'h04030201);
    t = 0; while (bus.gnt0 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    bus.req0 = 1'b0;
    checks++; if (t >= 50) begin failures++; $display("FAIL single_gnt_timeout waited=%0d want<50", t); end
    t = 0; while (bus.done !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    checks++; if (t >= 1000) begin failures++; $display("FAIL single_done_timeout waited=%0d want<1000", t); end
    repeat (2) @(negedge clk);
    checks++; if (n_g0 - b_g0 != 1) begin failures++; $display("FAIL single_gnt0_count got=%0d want=1", n_g0 - b_g0); end
    checks++; if (n_g1 - b_g1 != 0) begin failures++; $display("FAIL single_gnt1_count got=%0d want=0", n_g1 - b_g1); end
    checks++; if (n_tx - b_tx != NB) begin failures++; $display("FAIL single_tx_count got=%0d want=%0d", n_tx - b_tx, NB); end
    checks++; if (n_done - b_d != 1) begin failures++; $display("FAIL single_done_count got=%0d want=1", n_done - b_d); end
    checks++; if (bus.owner !== 1'b0) begin failures++; $display("FAIL single_owner got=%b want=0", bus.owner); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b want=0", bus.busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_q.size()) begin failures++; $display("FAIL single_byte missing want=%h", e); end
      else begin
        if (obs_q[rd] !== e) begin failures++; $display("FAIL single_byte got=%h want=%h", obs_q[rd], e); end
        rd++;
      end
    end
    repeat (IDLE_GAP + 4) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int t;
    int b_gi, b_di;
    logic [7:0] e;
    do_reset();
    b_gi = g_id_q.size(); b_di = d_cyc_q.size();
    bus.din0 = 32'h11111111; bus.din1 = 32'h22222222;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    push_word(1'b0, 32'h11111111);
    push_word(1'b1, 32'h22222222);
    t = 0;
    while ((bus.req0 || bus.req1) && t < 3000) begin
      @(negedge clk); t++;
      if (bus.gnt0 === 1'b1) bus.req0 = 1'b0;
      if (bus.gnt1 === 1'b1) bus.req1 = 1'b0;
    end
    checks++; if (t >= 3000) begin failures++; $display("FAIL rr_gnt_timeout waited=%0d want<3000", t); end
    t = 0; while (d_cyc_q.size() < b_di + 2 && t < 1000) begin @(negedge clk); t++; end
    checks++; if (t >= 1000) begin failures++; $display("FAIL rr_done_timeout dones=%0d want=2", d_cyc_q.size() - b_di); end
    repeat (2) @(negedge clk);
    checks++;
    if (g_id_q.size() < b_gi + 2 || d_cyc_q.size() < b_di + 1) begin
      failures++; $display("FAIL rr_order grants=%0d want=2", g_id_q.size() - b_gi);
    end else begin
      if (g_id_q[b_gi] !== 1'b0 || g_id_q[b_gi+1] !== 1'b1) begin
        failures++; $display("FAIL rr_order got=%b,%b want=0,1", g_id_q[b_gi], g_id_q[b_gi+1]);
      end
      checks++;
      if (g_cyc_q[b_gi+1] - d_cyc_q[b_di] != IDLE_GAP + 2) begin
        failures++; $display("FAIL rr_gap got=%0d want=%0d", g_cyc_q[b_gi+1] - d_cyc_q[b_di], IDLE_GAP + 2);
      end
    end
    checks++; if (bus.owner !== 1'b1) begin failures++; $display("FAIL rr_owner got=%b want=1", bus.owner); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_q.size()) begin failures++; $display("FAIL rr_byte missing want=%h", e); end
      else begin
        if (obs_q[rd] !== e) begin failures++; $display("FAIL rr_byte got=%h want=%h", obs_q[rd], e); end
        rd++;
      end
    end
    repeat (IDLE_GAP + 4) @(negedge clk);
  endtask

  task automatic test_hold_busy();
    int t;
    int b_tx = n_tx, b_d = n_done;
    logic [7:0] e;
    uart_hold = 1'b1;
    bus.din0 = 32'hDEADBEEF; bus.req0 = 1'b1;
    push_word(1'b0, 32'hDEADBEEF);
    t = 0; while (bus.gnt0 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    bus.req0 = 1'b0;
    checks++; if (t >= 50) begin failures++; $display("FAIL hold_gnt_timeout waited=%0d want<50", t); end
    repeat (20) @(negedge clk);
    checks++; if (n_tx != b_tx) begin failures++; $display("FAIL hold_no_transmit got=%0d want=0", n_tx - b_tx); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b want=1", bus.busy); end
    uart_hold = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (n_tx - b_tx != 1) begin failures++; $display("FAIL hold_one_transmit got=%0d want=1", n_tx - b_tx); end
    t = 0; while (bus.done !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    checks++; if (t >= 1000) begin failures++; $display("FAIL hold_done_timeout waited=%0d want<1000", t); end
    repeat (2) @(negedge clk);
    checks++; if (n_done - b_d != 1) begin failures++; $display("FAIL hold_done_count got=%0d want=1", n_done - b_d); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_q.size()) begin failures++; $display("FAIL hold_byte missing want=%h", e); end
      else begin
        if (obs_q[rd] !== e) begin failures++; $display("FAIL hold_byte got=%h want=%h", obs_q[rd], e); end
        rd++;
      end
    end
    repeat (IDLE_GAP + 4) @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    int t;
    int b_tx = n_tx, b_d = n_done, b_g1 = n_g1;
    logic [7:0] e;
    bus.din0 = 32'hAABBCCDD; bus.req0 = 1'b1;
`ifdef WORD_TX_ARB_HDR_EN
    exp_q.push_back(8'hA0); exp_q.push_back(8'hDD);
`else
    exp_q.push_back(8'hDD); exp_q.push_back(8'hCC);
`endif
    t = 0; while (bus.gnt0 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    bus.req0 = 1'b0;
    checks++; if (t >= 50) begin failures++; $display("FAIL mid_gnt_timeout waited=%0d want<50", t); end
    t = 0; while (n_tx - b_tx < 2 && t < 500) begin @(negedge clk); t++; end
    checks++; if (t >= 500) begin failures++; $display("FAIL mid_byte2_timeout tx=%0d want=2", n_tx - b_tx); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.transmit !== 1'b0) begin failures++; $display("FAIL mid_transmit got=%b want=0", bus.transmit); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (n_done != b_d) begin failures++; $display("FAIL mid_no_done got=%0d want=0", n_done - b_d); end
    checks++; if (n_tx - b_tx != 2) begin failures++; $display("FAIL mid_tx_count got=%0d want=2", n_tx - b_tx); end
    bus.din1 = 32'h55667788; bus.req1 = 1'b1;
    push_word(1'b1, 32'h55667788);
    t = 0; while (bus.gnt1 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    bus.req1 = 1'b0;
    checks++; if (t >= 100) begin failures++; $display("FAIL mid_gnt1_timeout waited=%0d want<100", t); end
    t = 0; while (bus.done !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    checks++; if (t >= 1000) begin failures++; $display("FAIL mid_done_timeout waited=%0d want<1000", t); end
    repeat (2) @(negedge clk);
    checks++; if (n_g1 - b_g1 != 1) begin failures++; $display("FAIL mid_gnt1_count got=%0d want=1", n_g1 - b_g1); end
    checks++; if (n_tx - b_tx != 2 + NB) begin failures++; $display("FAIL mid_total_tx got=%0d want=%0d", n_tx - b_tx, 2 + NB); end
    checks++; if (n_done - b_d != 1) begin failures++; $display("FAIL mid_done_count got=%0d want=1", n_done - b_d); end
    checks++; if (bus.owner !== 1'b1) begin failures++; $display("FAIL mid_owner got=%b want=1", bus.owner); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_q.size()) begin failures++; $display("FAIL mid_byte missing want=%h", e); end
      else begin
        if (obs_q[rd] !== e) begin failures++; $display("FAIL mid_byte got=%h want=%h", obs_q[rd], e); end
        rd++;
      end
    end
    repeat (IDLE_GAP + 4) @(negedge clk);
  endtask

  task automatic test_header();
    int t;
    int b_tx = n_tx;
    logic [7:0] e;
    bus.din1 = 32'h44332211; bus.req1 = 1'b1;
    push_word(1'b1, 32'h44332211);
    t = 0; while (bus.gnt1 !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    bus.req1 = 1'b0;
    checks++; if (t >= 50) begin failures++; $display("FAIL hdr_gnt_timeout waited=%0d want<50", t); end
    t = 0; while (bus.done !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    checks++; if (t >= 1000) begin failures++; $display("FAIL hdr_done_timeout waited=%0d want<1000", t); end
    repeat (2) @(negedge clk);
    checks++; if (n_tx - b_tx != NB) begin failures++; $display("FAIL hdr_tx_count got=%0d want=%0d", n_tx - b_tx, NB); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rd >= obs_q.size()) begin failures++; $display("FAIL hdr_byte missing want=%h", e); end
      else begin
        if (obs_q[rd] !== e) begin failures++; $display("FAIL hdr_byte got=%h want=%h", obs_q[rd], e); end
        rd++;
      end
    end
    checks++; if (obs_q.size() != rd) begin failures++; $display("FAIL extra_bytes got=%0d want=0", obs_q.size() - rd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold_busy();
    test_reset_mid_word();
    test_header();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/word_tx_arb.md
WORD_TX_ARB -- requirements
Module: word_tx_arb

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 16, the number of idle clk cycles after each word before the next grant.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  input  1  word-send request from requester 0/1; held high until granted.
REQ-005 SHALL have ports din0/din1  input  32  word from requester 0/1; stable while the matching req is high.
REQ-006 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: word from requester 0/1 captured.
REQ-007 SHALL have port transmit  output  1  start strobe to the UART transmitter.
REQ-008 SHALL have port tx_byte  output  8  byte presented to the UART transmitter.
REQ-009 SHALL have port is_transmitting  input  1  UART transmit line busy.
REQ-010 SHALL have port busy  output  1  high from grant until the word's last byte completes.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the word's last byte completes.
REQ-012 SHALL have port owner  output  1  id of the requester owning the current or last word.

Function
REQ-013 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE and GAP.
REQ-014 In IDLE with any req high, SHALL capture the winning din at that edge, pulse the matching gnt for the next cycle, set owner and busy, clear the byte counter, and enter START.
REQ-015 Arbitration SHALL be round-robin: with one req high, that requester wins; with both high, the requester not granted last wins; after reset, requester 0 has priority.
REQ-016 SHALL send bytes in the order word[7:0], [15:8], [23:16], [31:24]; tx_byte SHALL hold the current byte from START through WAIT_DONE.
REQ-017 In START with is_transmitting low, SHALL assert transmit for exactly one cycle and enter WAIT_BUSY; with is_transmitting high, SHALL hold START with transmit low.
REQ-018 In WAIT_BUSY, SHALL go to WAIT_DONE when is_transmitting is high.
REQ-019 In WAIT_DONE, SHALL act when is_transmitting is low: if bytes remain, increment the byte counter and enter START; after byte 3, pulse done, clear busy, load the gap counter with IDLE_GAP and enter GAP.
REQ-020 GAP SHALL count down to 0 and then enter IDLE; with IDLE_GAP=0, GAP SHALL last one cycle.
REQ-021 Requests SHALL be ignored (no gnt) in all states except IDLE.
REQ-022 The byte counter SHALL be 2 bits and SHALL NOT wrap within a word; the gap counter SHALL be wide enough for IDLE_GAP.

Reset
REQ-023 While rst is low at a rising edge, the block SHALL enter IDLE and drive gnt0=gnt1=0, transmit=0, tx_byte=8'h00, busy=0, done=0 and owner=0, with the round-robin pointer set to favour requester 0.
REQ-024 Reset mid-word SHALL abandon the word without a done pulse; transmit SHALL be low from the first reset edge.

Configuration
REQ-025 With macro WORD_TX_ARB_HDR_EN defined, each word SHALL be preceded by a header byte 8'hA0 | {7'b0, owner}, sent with the same START/WAIT handshake, making 5 bytes per word; done timing SHALL be unchanged relative to the last data byte.
REQ-026 With WORD_TX_ARB_HDR_EN undefined, no header SHALL be sent and exactly 4 bytes SHALL be sent per word.

Verification
REQ-027 Bench SHALL cover: req0=1, din0=32'h04030201, UART model busy 10 cycles per byte -> gnt0 pulses once; tx_byte sequence 01,02,03,04; four transmit pulses; one done pulse; owner=0.
REQ-028 Bench SHALL cover: req0 and req1 high together (din0=32'h11111111, din1=32'h22222222) held until granted -> words sent in the order requester 0 then requester 1; second grant only after IDLE_GAP cycles in GAP.
REQ-029 Bench SHALL cover: is_transmitting held high when START is entered -> transmit stays 0 until is_transmitting falls, then exactly one transmit pulse.
REQ-030 Bench SHALL cover: rst low after byte 2 has started -> next cycle transmit=0, busy=0, no done pulse; a later req1 is granted and sent in full.
REQ-031 Bench SHALL cover: with WORD_TX_ARB_HDR_EN defined, req1 with din1=32'h44332211 -> tx_byte sequence A1,11,22,33,44 with five transmit pulses.
